// File: rtl/tape_pkg.sv
// Shared timing and decode definitions for the tape square-wave path.
// The tape generator and the decoder both use this package.
//   - Low-phase decode windows and the high-phase idle timeout, in 24 MHz cycles.
//   - Bit-cell lengths (low phase / full cell) for '1' and '0' symbols.
//   - Counter width, decoder state codes, the bit class enum and the low-phase
//     classifier.
package tape_pkg;

  localparam int LOW1_MIN   = 3000;
  localparam int LOW_THRESH = 5442;
  localparam int LOW0_MAX   = 9000;
  localparam int HIGH_TMO   = 12000;

  // A '1' cell is 4354 low / 8708 total; a '0' cell is 6530 low / 15239 total.
  localparam int T1_LOW  = 4354;
  localparam int T1_CELL = 8708;
  localparam int T0_LOW  = 6530;
  localparam int T0_CELL = 15239;

  localparam int CNT_W = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef enum logic [1:0] {
    BIT_INV  = 2'd0,
    BIT_ZERO = 2'd1,
    BIT_ONE  = 2'd2
  } bit_cls_t;

  // A saturated count means the low phase ran off the end of the counter, so
  // its true length is unknown and it can never be a valid bit.
  function automatic bit_cls_t classify_low(input logic [CNT_W-1:0] l,
                                            input int min1,
                                            input int thr,
                                            input int max0);
    int lv;
    lv = int'({{(32-CNT_W){1'b0}}, l});
    if (l == CNT_MAX)                return BIT_INV;
    if (lv >= min1 && lv < thr)      return BIT_ONE;
    if (lv >= thr && lv <= max0)     return BIT_ZERO;
    return BIT_INV;
  endfunction

endpackage

// File: rtl/tape_sync.sv
// Two-flop synchroniser for the tape input plus level-change detection.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   din        : asynchronous tape level
//   s          : synchronised level
//   rise, fall : one-cycle strobes, s changed 0->1 / 1->0 on the last clock
module tape_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      s_q     <= sync_p1;
    end
  end

  assign s    = sync_p1;
  assign rise = sync_p1 & ~s_q;
  assign fall = ~sync_p1 & s_q;

endmodule

// File: rtl/square_dec.sv
// Tape square-wave byte decoder.
// Each symbol is a low phase followed by a high phase; the low-phase length
// decides the bit. A frame is a '0' start bit, 8 data bits LSB first, an odd
// parity bit and a '1' stop bit.
// Ports:
//   clk, reset  : 24 MHz clock, asynchronous active-high reset
//   din         : asynchronous tape input, idle low
//   dout        : last byte received with a good stop bit
//   valid       : one-cycle pulse when dout is updated
//   parity_err  : one-cycle pulse alongside valid when parity is wrong
//   frame_err   : one-cycle pulse when a frame is aborted
//   busy        : high while a frame is in progress
module square_dec #(
  parameter int LOW1_MIN   = tape_pkg::LOW1_MIN,
  parameter int LOW_THRESH = tape_pkg::LOW_THRESH,
  parameter int LOW0_MAX   = tape_pkg::LOW0_MAX,
  parameter int HIGH_TMO   = tape_pkg::HIGH_TMO
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  import tape_pkg::*;

  logic             s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [1:0]       state;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             exp_par;
  logic             tmo;
  bit_cls_t         cls;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  tape_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  // Phase-length counters: each restarts on the edge that begins the
  // opposite level, so low_cnt still holds the full low length on the
  // clock that sees rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      if (rise)
        low_cnt <= '0;
      else if (!s)
        low_cnt <= sat_inc(low_cnt);

      if (fall)
        high_cnt <= '0;
      else if (s)
        high_cnt <= sat_inc(high_cnt);
    end
  end

  always_comb begin
    cls = classify_low(low_cnt, LOW1_MIN, LOW_THRESH, LOW0_MAX);
  end

  // Odd parity over data plus parity bit.
  assign exp_par = ~^shreg;
  assign tmo     = ({{(32-CNT_W){1'b0}}, high_cnt} == 32'(HIGH_TMO));
  assign busy    = (state != ST_HUNT);

  // Frame sequencing: decisions are taken on rise; outputs are registered, so
  // pulses appear on the cycle after that clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_HUNT;
      bit_idx    <= 3'd0;
      dout       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (rise) begin
        case (state)
          ST_HUNT: begin
            // Leader ones, trailing stop ones and junk are ignored here.
            if (cls == BIT_ZERO) begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end
          end
          ST_DATA: begin
            if (cls == BIT_INV) begin
              frame_err <= 1'b1;
              state     <= ST_HUNT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7)
                state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (cls == BIT_INV) begin
              frame_err <= 1'b1;
              state     <= ST_HUNT;
            end else begin
              state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (cls == BIT_ONE) begin
              dout       <= shreg;
              valid      <= 1'b1;
              parity_err <= (par_bit != exp_par);
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end else if (tmo && state != ST_HUNT) begin
        frame_err <= 1'b1;
        state     <= ST_HUNT;
      end
    end
  end

  // Byte assembly: shift right so the first data bit lands in bit 0.
  always_ff @(posedge clk) begin
    if (rise && state == ST_DATA && cls != BIT_INV)
      shreg <= {cls == BIT_ONE, shreg[7:1]};
    if (rise && state == ST_PARITY)
      par_bit <= (cls == BIT_ONE);
  end

endmodule

// File: tb/tb_square_dec.sv
module tb_square_dec;
  import tape_pkg::*;

  // Timing scaled down by 100 so whole frames fit a short run.
  localparam int P_LOW1_MIN   = LOW1_MIN / 100;
  localparam int P_LOW_THRESH = LOW_THRESH / 100;
  localparam int P_LOW0_MAX   = LOW0_MAX / 100;
  localparam int P_HIGH_TMO   = HIGH_TMO / 100;
  localparam int ONE_L   = T1_LOW / 100;
  localparam int ONE_H   = (T1_CELL - T1_LOW) / 100;
  localparam int ZERO_L  = T0_LOW / 100;
  localparam int ZERO_H  = (T0_CELL - T0_LOW) / 100;
  localparam int GLITCH_L = 10;
  localparam int TMO_H    = 150;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic [7:0] dout;
  logic       valid, parity_err, frame_err, busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       v;
    logic       pe;
    logic       fe;
    logic [7:0] d;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         stop;
    logic       exp_v;
    logic       exp_pe;
    logic       exp_fe;
    logic [7:0] exp_dout;
  } vec_t;

  // Reference model state: -1 hunting, 0..7 data bit index, 8 parity, 9 stop.
  int         m_pos = -1;
  logic [7:0] m_byte;
  int         m_par;

  square_dec #(
    .LOW1_MIN   (P_LOW1_MIN),
    .LOW_THRESH (P_LOW_THRESH),
    .LOW0_MAX   (P_LOW0_MAX),
    .HIGH_TMO   (P_HIGH_TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid || parity_err || frame_err) begin
      checks++;
      if ((frame_err && (valid || parity_err)) || (parity_err && !valid)) begin
        errors++;
        $display("FAIL pulse_combo: valid=%0b parity_err=%0b frame_err=%0b", valid, parity_err, frame_err);
      end
      obs_q.push_back('{v: valid, pe: parity_err, fe: frame_err, d: dout});
    end
  end

  initial begin
    #1_200_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic model_phase(input int l, input int h);
    int c;
    if (l >= 16383)                              c = -1;
    else if (l >= P_LOW1_MIN && l < P_LOW_THRESH) c = 1;
    else if (l >= P_LOW_THRESH && l <= P_LOW0_MAX) c = 0;
    else                                          c = -1;
    if (m_pos < 0) begin
      if (c == 0) m_pos = 0;
    end else if (c < 0) begin
      exp_q.push_back('{v: 1'b0, pe: 1'b0, fe: 1'b1, d: 8'h00});
      m_pos = -1;
    end else if (m_pos < 8) begin
      m_byte[m_pos] = (c == 1);
      m_pos++;
    end else if (m_pos == 8) begin
      m_par = c;
      m_pos = 9;
    end else begin
      if (c == 1)
        exp_q.push_back('{v: 1'b1, pe: (($countones(m_byte) + m_par) % 2 == 0), fe: 1'b0, d: m_byte});
      else
        exp_q.push_back('{v: 1'b0, pe: 1'b0, fe: 1'b1, d: 8'h00});
      m_pos = -1;
    end
    if (m_pos >= 0 && h >= P_HIGH_TMO) begin
      exp_q.push_back('{v: 1'b0, pe: 1'b0, fe: 1'b1, d: 8'h00});
      m_pos = -1;
    end
  endtask

  task automatic send_phase(input int l, input int h);
    model_phase(l, h);
    din = 1'b0;
    repeat (l) @(negedge clk);
    din = 1'b1;
    repeat (h) @(negedge clk);
  endtask

  task automatic send_sym(input bit b);
    if (b) send_phase(ONE_L, ONE_H);
    else   send_phase(ZERO_L, ZERO_H);
  endtask

  task automatic send_sep();
    send_phase(200, 50);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    send_sym(1'b0);
    for (int i = 0; i < n; i++) send_sym(b[i]);
  endtask

  // bad_kind 1: glitch replaces symbol bad_pos; 2: symbol bad_pos has a long high.
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop,
                            input int bad_pos, input int bad_kind);
    logic [10:0] syms;
    bit p;
    p = ($countones(b) % 2 == 0) ^ flip;
    syms = {stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == bad_pos && bad_kind == 1)      send_phase(GLITCH_L, ONE_H);
      else if (i == bad_pos && bad_kind == 2) send_phase(syms[i] ? ONE_L : ZERO_L, TMO_H);
      else                                    send_sym(syms[i]);
    end
  endtask

  task automatic check_events(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i].v !== exp_q[i].v || obs_q[i].pe !== exp_q[i].pe || obs_q[i].fe !== exp_q[i].fe ||
            (exp_q[i].v && obs_q[i].d !== exp_q[i].d)) begin
          errors++;
          $display("FAIL %s event %0d: got v=%0b pe=%0b fe=%0b d=%h want v=%0b pe=%0b fe=%0b d=%h",
                   name, i, obs_q[i].v, obs_q[i].pe, obs_q[i].fe, obs_q[i].d,
                   exp_q[i].v, exp_q[i].pe, exp_q[i].fe, exp_q[i].d);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst_dout",  32'(dout), 32'h00);
    check_val("rst_valid", 32'(valid), 0);
    check_val("rst_perr",  32'(parity_err), 0);
    check_val("rst_ferr",  32'(frame_err), 0);
    check_val("rst_busy",  32'(busy), 0);
    reset = 1'b0;
    send_sep();
    check_events("idle");

    // Valid timing on the stop bit: din rises, two sync flops, then the register.
    send_partial(8'h96, 8);
    send_sym(1'b1);
    model_phase(ONE_L, ONE_H);
    din = 1'b0;
    repeat (ONE_L) @(negedge clk);
    din = 1'b1;
    @(posedge clk); #1 check_val("lat_e0", 32'(valid), 0);
    @(posedge clk); #1 check_val("lat_e1", 32'(valid), 0);
    @(posedge clk); #1 check_val("lat_e2", 32'(valid), 1);
    check_val("lat_dout", 32'(dout), 32'h96);
    @(posedge clk); #1 check_val("lat_e3", 32'(valid), 0);
    check_val("lat_busy", 32'(busy), 0);
    repeat (ONE_H - 4) @(negedge clk);
    send_sep();
    check_events("latency");

    // Table of whole frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop, -1, 0);
      send_sep();
      checks++;
      if (obs_q.size() != 1) begin
        errors++;
        $display("FAIL table%0d pulses: got %0d want 1", i, obs_q.size());
      end else begin
        checks++;
        if (obs_q[0].v !== vecs[i].exp_v || obs_q[0].pe !== vecs[i].exp_pe || obs_q[0].fe !== vecs[i].exp_fe) begin
          errors++;
          $display("FAIL table%0d flags: got v=%0b pe=%0b fe=%0b want v=%0b pe=%0b fe=%0b", i,
                   obs_q[0].v, obs_q[0].pe, obs_q[0].fe, vecs[i].exp_v, vecs[i].exp_pe, vecs[i].exp_fe);
        end
      end
      check_val($sformatf("table%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      check_val($sformatf("table%0d_busy", i), 32'(busy), 0);
      check_events($sformatf("table%0d_model", i));
    end

    // Leader ones then two back-to-back bytes.
    repeat (100) send_sym(1'b1);
    send_frame(8'h00, 1'b0, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 0);
    send_sep();
    checks++;
    if (obs_q.size() != 2 || !obs_q[0].v || obs_q[0].d !== 8'h00 || !obs_q[1].v || obs_q[1].d !== 8'hFF) begin
      errors++;
      $display("FAIL gap_bytes: got %0d events", obs_q.size());
    end
    check_events("gap_model");

    // Short glitch while hunting, then as data bit 3.
    send_phase(GLITCH_L, ONE_H);
    check_events("glitch_hunt");
    send_partial(8'h00, 3);
    send_phase(GLITCH_L, ONE_H);
    check_val("glitch_busy", 32'(busy), 0);
    send_sep();
    check_events("glitch_data");

    // Line stuck high after data bit 4.
    send_partial(8'h00, 4);
    send_phase(ZERO_L, TMO_H);
    check_val("tmo_busy", 32'(busy), 0);
    send_sep();
    check_events("timeout");

    // Low phase longer than the counter range.
    send_partial(8'h00, 1);
    send_phase(16400, ONE_H);
    send_sep();
    check_events("low_sat");

    // Reset in the middle of a frame.
    send_partial(8'hC3, 6);
    check_val("mid_busy", 32'(busy), 1);
    din = 1'b0;
    reset = 1'b1;
    m_pos = -1;
    repeat (2) @(negedge clk);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_dout", 32'(dout), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_events("mid_reset");
    send_sep();
    send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
    send_sep();
    check_val("after_rst_dout", 32'(dout), 32'h5A);
    check_events("after_reset");

    // Randomised frames with occasional faults.
    for (int r = 0; r < 12; r++) begin
      logic [7:0] b;
      int kind, pos;
      b    = 8'($urandom);
      kind = $urandom_range(0, 7);
      pos  = $urandom_range(1, 10);
      repeat ($urandom_range(0, 3)) send_sym(1'b1);
      case (kind)
        0:       send_frame(b, 1'b1, 1'b1, -1, 0);
        1:       send_frame(b, 1'b0, 1'b0, -1, 0);
        2:       send_frame(b, 1'b0, 1'b1, pos, 1);
        3:       send_frame(b, 1'b0, 1'b1, pos, 2);
        default: send_frame(b, 1'b0, 1'b1, -1, 0);
      endcase
      send_sep();
      check_events($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/square_dec.md
SQUARE_DEC -- requirements
Module: square_dec

Interface
REQ-001 SHALL have parameter LOW1_MIN, default 3000, minimum low-phase cycles accepted as a bit.
REQ-002 SHALL have parameter LOW_THRESH, default 5442, low-phase cycles at or above which a bit decodes as 0, below as 1.
REQ-003 SHALL have parameter LOW0_MAX, default 9000, maximum low-phase cycles accepted as a bit.
REQ-004 SHALL have parameter HIGH_TMO, default 12000, high-phase cycles after which the line counts as idle.
REQ-005 SHALL have port clk  input  1  system clock, 24 MHz.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port din  input  1  asynchronous tape square wave, idle low, each bit a low phase then a high phase.
REQ-008 SHALL have port dout  output  8  last received byte.
REQ-009 SHALL have port valid  output  1  one-cycle pulse, dout updated.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse coincident with valid when parity mismatches.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on aborted frame.
REQ-012 SHALL have port busy  output  1  high while state is not HUNT.

Function
REQ-013 SHALL pass din through a 2-flop synchroniser; the synchronised level is s, and all timing below refers to s.
REQ-014 SHALL count consecutive s=0 cycles in a 14-bit low counter (saturating at 16383) and consecutive s=1 cycles in a 14-bit high counter (saturating); each clears on the opposite level.
REQ-015 SHALL classify a bit on each s rising edge from low count L: 1 if LOW1_MIN<=L<LOW_THRESH; 0 if LOW_THRESH<=L<=LOW0_MAX; otherwise invalid.
REQ-016 SHALL implement states HUNT, DATA, PARITY, STOP, tracking data bits with a 3-bit index.
REQ-017 In HUNT: bit 0 -> DATA with index 0; bit 1 or invalid -> remain in HUNT, no error, so gap/leader ones are ignored.
REQ-018 In DATA: each valid bit shifts into the byte LSB-first; after the 8th bit -> PARITY.
REQ-019 In PARITY: latch the bit -> STOP; expected parity = 1 XOR (XOR of the 8 data bits), i.e. odd parity over data plus parity bit.
REQ-020 In STOP: bit 1 -> dout loaded, valid pulsed, parity_err pulsed on mismatch, -> HUNT; bit 0 or invalid -> frame_err pulsed, dout unchanged, -> HUNT.
REQ-021 SHALL pulse valid exactly one cycle after the clock on which the STOP bit's rising edge of s is detected.
REQ-022 Invalid bit in DATA or PARITY -> frame_err pulse, -> HUNT.
REQ-023 High count reaching HIGH_TMO in DATA, PARITY or STOP -> frame_err pulse, -> HUNT; in HUNT no effect.
REQ-024 A low count saturating at 16383 SHALL classify as invalid at the next rising edge.
REQ-025 Trailing stop ones after the first SHALL be absorbed in HUNT with no output.
REQ-026 valid, parity_err and frame_err SHALL never be asserted in the same cycle except valid with parity_err.

Reset
REQ-027 Reset SHALL force state HUNT, counters 0, synchroniser 0, dout 8'h00, valid 0, parity_err 0, frame_err 0, busy 0.
REQ-028 Reset mid-frame SHALL discard the partial byte with no pulses; decoding resumes at the next start bit.

Structure
REQ-029 Timing constants (LOW1_MIN, LOW_THRESH, LOW0_MAX, HIGH_TMO, bit-cell cycle counts 4354/8708 and 6530/15239) SHALL live in shared package tape_pkg, also used by the tape generator.
REQ-030 Synchroniser plus edge detect SHALL be one sub-module, tape_sync (clk, reset, din -> s, rise, fall).

Verification
REQ-031 Loopback from the tape generator, byte 8'hA5 (parity bit 1) -> one valid, dout 8'hA5, no errors, busy low after.
REQ-032 Frame 8'h3C with parity bit forced 0 -> valid with dout 8'h3C and parity_err in the same cycle.
REQ-033 100 gap ones, then byte 8'h00, then byte 8'hFF -> exactly two valids, 8'h00 then 8'hFF.
REQ-034 1000-cycle low glitch in HUNT -> no pulses; the same glitch as data bit 3 -> frame_err, state HUNT.
REQ-035 Stop bit sent as 0 (6530 low) -> frame_err, dout keeps its previous value; line held high 12000 cycles after bit 4 -> frame_err.
REQ-036 Reset asserted after data bit 5, then a full frame for 8'h5A -> no pulses during reset, then one valid with 8'h5A.
